// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational read ports,
// sticky out-of-range error flag. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_sel1,
  input  logic [ADDR_W-1:0] rd_sel2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              err
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_err;
  logic [DEPTH-1:0] w_we;
  logic             w_wr_ok;
  logic             w_rd1_ok;
  logic             w_rd2_ok;
  logic             w_err_set;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  // Index range checks only matter when DEPTH is not a power of two.
  assign w_wr_ok   = {1'b0, wr_sel}  < LP_DEPTH;
  assign w_rd1_ok  = {1'b0, rd_sel1} < LP_DEPTH;
  assign w_rd2_ok  = {1'b0, rd_sel2} < LP_DEPTH;
  assign w_err_set = (wr_en && !w_wr_ok) || !w_rd1_ok || !w_rd2_ok;

  always_comb begin
    w_we = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_we[k] = wr_en && (wr_sel == ADDR_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_we[k]) r_mem[k] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  // Unmatched indices fall through to zero.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_sel1 == ADDR_W'(k)) w_rd1 = r_mem[k];
      if (rd_sel2 == ADDR_W'(k)) w_rd2 = r_mem[k];
    end
  end

`ifdef RF_BYPASS_EN
  assign rd_data1 = (rst && wr_en && w_wr_ok && (rd_sel1 == wr_sel)) ? wr_data : w_rd1;
  assign rd_data2 = (rst && wr_en && w_wr_ok && (rd_sel2 == wr_sel)) ? wr_data : w_rd2;
`else
  assign rd_data1 = w_rd1;
  assign rd_data2 = w_rd2;
`endif

  assign err = r_err;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: four instances (16x8, 16x6, 1x2, 32x2) against an
// array-based reference model; honours RF_BYPASS_EN when defined.
module tb_regfile_param;

  logic clk;
  logic rst;

  // group h: 3-bit index instances A (DEPTH 8) and B (DEPTH 6) share stimulus
  logic        wen_h;
  logic [2:0]  wsel_h, rs1_h, rs2_h;
  logic [15:0] wdat_h;
  // group n: 1-bit index instances C (WIDTH 1) and D (WIDTH 32) share stimulus
  logic        wen_n;
  logic        wsel_n, rs1_n, rs2_n;
  logic [31:0] wdat_n;

  logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        rd1_c, rd2_c;
  logic [31:0] rd1_d, rd2_d;
  logic        err_a, err_b, err_c, err_d;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m   [4][8];
  logic        e   [4];
  int          dep [4] = '{8, 6, 2, 2};
  logic [31:0] msk [4] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};

  regfile_param #(.WIDTH(16), .DEPTH(8)) u_a (
    .clk(clk), .rst(rst), .wr_en(wen_h), .wr_sel(wsel_h), .wr_data(wdat_h),
    .rd_sel1(rs1_h), .rd_sel2(rs2_h), .rd_data1(rd1_a), .rd_data2(rd2_a), .err(err_a));
  regfile_param #(.WIDTH(16), .DEPTH(6)) u_b (
    .clk(clk), .rst(rst), .wr_en(wen_h), .wr_sel(wsel_h), .wr_data(wdat_h),
    .rd_sel1(rs1_h), .rd_sel2(rs2_h), .rd_data1(rd1_b), .rd_data2(rd2_b), .err(err_b));
  regfile_param #(.WIDTH(1), .DEPTH(2)) u_c (
    .clk(clk), .rst(rst), .wr_en(wen_n), .wr_sel(wsel_n), .wr_data(wdat_n[0]),
    .rd_sel1(rs1_n), .rd_sel2(rs2_n), .rd_data1(rd1_c), .rd_data2(rd2_c), .err(err_c));
  regfile_param #(.WIDTH(32), .DEPTH(2)) u_d (
    .clk(clk), .rst(rst), .wr_en(wen_n), .wr_sel(wsel_n), .wr_data(wdat_n),
    .rd_sel1(rs1_n), .rd_sel2(rs2_n), .rd_data1(rd1_d), .rd_data2(rd2_d), .err(err_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void inp(input int i, output logic we, output int ws,
                              output int r1, output int r2, output logic [31:0] wd);
    if (i < 2) begin
      we = wen_h; ws = int'(wsel_h); r1 = int'(rs1_h); r2 = int'(rs2_h); wd = {16'b0, wdat_h};
    end else begin
      we = wen_n; ws = int'(wsel_n); r1 = int'(rs1_n); r2 = int'(rs2_n); wd = wdat_n;
    end
    wd = wd & msk[i];
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input int port);
    logic we; int ws, r1, r2, sel; logic [31:0] wd;
    inp(i, we, ws, r1, r2, wd);
    sel = (port == 1) ? r1 : r2;
    if (!rst) return 32'b0;
`ifdef RF_BYPASS_EN
    if (we && ws < dep[i] && sel == ws) return wd;
`endif
    if (sel < dep[i]) return m[i][sel];
    return 32'b0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      e[i] = 1'b0;
      for (int j = 0; j < 8; j++) m[i][j] = 32'b0;
    end
  endfunction

  function automatic void model_edge();
    logic we; int ws, r1, r2; logic [31:0] wd;
    for (int i = 0; i < 4; i++) begin
      inp(i, we, ws, r1, r2, wd);
      if (rst) begin
        if (we && ws < dep[i]) m[i][ws] = wd;
        if ((we && ws >= dep[i]) || r1 >= dep[i] || r2 >= dep[i]) e[i] = 1'b1;
      end
    end
    if (!rst) model_clear();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/A.rd1"}, {16'b0, rd1_a}, exp_rd(0, 1));
    chk({tag, "/A.rd2"}, {16'b0, rd2_a}, exp_rd(0, 2));
    chk({tag, "/A.err"}, {31'b0, err_a}, {31'b0, e[0]});
    chk({tag, "/B.rd1"}, {16'b0, rd1_b}, exp_rd(1, 1));
    chk({tag, "/B.rd2"}, {16'b0, rd2_b}, exp_rd(1, 2));
    chk({tag, "/B.err"}, {31'b0, err_b}, {31'b0, e[1]});
    chk({tag, "/C.rd1"}, {31'b0, rd1_c}, exp_rd(2, 1));
    chk({tag, "/C.rd2"}, {31'b0, rd2_c}, exp_rd(2, 2));
    chk({tag, "/C.err"}, {31'b0, err_c}, {31'b0, e[2]});
    chk({tag, "/D.rd1"}, rd1_d, exp_rd(3, 1));
    chk({tag, "/D.rd2"}, rd2_d, exp_rd(3, 2));
    chk({tag, "/D.err"}, {31'b0, err_d}, {31'b0, e[3]});
  endtask

  // Inputs are already set just after a negedge: check pre-edge, clock, check post-edge.
  task automatic cycle(input string tag);
    #1 check_all({tag, ":pre"});
    @(posedge clk);
    model_edge();
    #1 check_all({tag, ":post"});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wen_h = 1'b0; wsel_h = 3'd0; rs1_h = 3'd0; rs2_h = 3'd0; wdat_h = 16'h0;
    wen_n = 1'b0; wsel_n = 1'b0; rs1_n = 1'b0; rs2_n = 1'b0; wdat_n = 32'h0;
  endtask

  initial begin
    model_clear();
    rst    = 1'b0;
    wen_h  = 1'b1; wsel_h = 3'($urandom); wdat_h = 16'($urandom);
    rs1_h  = 3'($urandom); rs2_h = 3'($urandom);
    wen_n  = 1'b1; wsel_n = 1'($urandom); wdat_n = $urandom;
    rs1_n  = 1'($urandom); rs2_n = 1'($urandom);
    #1 check_all("reset_async");

    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    for (int s = 0; s < 6; s++) begin
      rs1_h = 3'(s); rs2_h = 3'(5 - s); rs1_n = 1'(s); rs2_n = 1'(s + 1);
      cycle("readall");
    end

    // same-index write/read, reg5 previously 0x0001
    wen_h = 1'b1; wsel_h = 3'd5; wdat_h = 16'h0001;
    cycle("pre_w5");
    wen_h = 1'b1; wsel_h = 3'd5; wdat_h = 16'hA5A5; rs1_h = 3'd5; rs2_h = 3'd4;
    cycle("same_idx");
    wen_h = 1'b0;
    cycle("same_idx_after");

    // out-of-range write on B (A legally writes reg 6)
    wen_h = 1'b1; wsel_h = 3'd6; wdat_h = 16'hFFFF; rs1_h = 3'd5; rs2_h = 3'd0;
    cycle("oor_wr");
    wen_h = 1'b0; rs2_h = 3'd7;
    cycle("oor_rd");
    rs2_h = 3'd1;
    for (int c = 0; c < 10; c++) cycle("err_sticky");

    // write/read back
    wen_h = 1'b1; wsel_h = 3'd3; wdat_h = 16'h1234;
    cycle("wr3");
    wsel_h = 3'd7; wdat_h = 16'hBEEF;
    cycle("wr7");
    wen_h = 1'b0; rs1_h = 3'd3; rs2_h = 3'd7;
    cycle("rb37");

    // randomized traffic on both groups
    for (int it = 0; it < 60; it++) begin
      wen_h = 1'($urandom); wsel_h = 3'($urandom); wdat_h = 16'($urandom);
      rs1_h = 3'($urandom); rs2_h = 3'($urandom);
      if ($urandom_range(0, 3) == 0) rs1_h = wsel_h;
      wen_n = 1'($urandom); wsel_n = 1'($urandom); wdat_n = $urandom;
      rs1_n = 1'($urandom); rs2_n = 1'($urandom);
      cycle("rand");
    end

    // reset mid-operation with a pending write
    idle_inputs();
    wen_h = 1'b1; wsel_h = 3'd2; wdat_h = 16'h00FF; rs1_h = 3'd2; rs2_h = 3'd2;
    cycle("wr2");
    #2 rst = 1'b0;
    model_clear();
    #1 check_all("mid_reset");
    @(negedge clk);
    cycle("in_reset1");
    cycle("in_reset2");
    wen_h = 1'b0;
    rst = 1'b1;
    cycle("released");

    // width sweep on the DEPTH=2 instances
    wen_n = 1'b1; wsel_n = 1'b1; wdat_n = 32'hFFFF_FFFF;
    cycle("sweep_w1");
    wsel_n = 1'b0; wdat_n = 32'h0;
    cycle("sweep_w0");
    wen_n = 1'b0; rs1_n = 1'b1; rs2_n = 1'b0;
    cycle("sweep_rd");
    rs1_n = 1'b0; rs2_n = 1'b1;
    cycle("sweep_rd_swap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
